ex_muldiv_seq: RTL
==================

# ex_muldiv_seq

Multi-cycle sequencer for the unsigned RV32M subset (MUL, MULHU, DIVU, REMU) in the EX stage. It sits beside the main ALU and is selected when ALU control decodes an R-type M-extension op. It runs a shift-add multiplier or restoring divider one bit per cycle and stalls the pipeline until the result is ready. It returns to idle on completion, flush or reset.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX holds an M-op (ALUOp=2'b10, funct7=0000001); level, held while stalled.
- funct3  in  3  000 MUL, 011 MULHU, 101 DIVU, 111 REMU; other codes are unsupported.
- rs1_val  in  XLEN  multiplicand / dividend.
- rs2_val  in  XLEN  multiplier / divisor.
- flush  in  1  synchronous abort from the branch/hazard unit.
- stall  out  1  combinational; freezes PC, IF/ID and ID/EX.
- done  out  1  registered; high for exactly one cycle when result is valid.
- result  out  XLEN  registered; holds the last completed value.

## Operation
States: IDLE, RUN, DONE.

- **IDLE**
  - Operation is accepted when start=1, funct3 is supported and flush=0.
  - On accept, latch operands, funct3 and zero iteration counter cnt.
  - Divisor zero with DIVU/REMU: go directly to DONE. result = all ones for DIVU, rs1_val for REMU.
  - Otherwise go to RUN.
  - Unsupported funct3: no accept, stall=0, result unchanged.
- **RUN**, one iteration per edge, cnt increments.
  - MUL/MULHU: 2*XLEN product register. If multiplier LSB is set, add multiplicand to the upper half. Then shift right by 1.
  - DIVU/REMU: shift {rem,quot} left by 1. If rem >= divisor, subtract divisor and set quot LSB.
  - At the edge completing iteration XLEN-1, write result and go to DONE:
    - MUL: product[XLEN-1:0]
    - MULHU: product[2XLEN-1:XLEN]
    - DIVU: quot
    - REMU: rem
- **DONE**
  - done=1 and stall=0, so ID/EX advances and EX/MEM captures result at the next edge.
  - start is ignored here because it is still the same instruction.
  - Unconditionally go to IDLE.

stall:
- 1 in IDLE when an operation is being accepted (start & supported & !flush).
- 1 throughout RUN.
- 0 otherwise, and 0 while rst_n=0.

flush:
- In any state, next edge goes to IDLE.
- No done pulse; result keeps its prior value.
- flush and start together in IDLE: flush wins, no accept.

Arithmetic:
- All unsigned; no overflow case exists.
- Internal adders/subtractors are XLEN+1 bits to capture carry/borrow.

Reset (asynchronous, rst_n=0):
- State IDLE, cnt=0, result=0, done=0, stall=0, internal registers 0.
- A reset mid-RUN discards the operation. After release, the block accepts a new start normally.

## Timing
- Call the accept edge E0.
- Normal ops:
  - RUN spans the cycles after E0..E(XLEN-1).
  - DONE entered at E(XLEN); done and result valid in the following cycle.
  - Pipeline advances at E(XLEN+1).
  - stall is high for XLEN+1 cycles (accept cycle plus XLEN RUN cycles).
- Divide-by-zero: DONE entered at E0; done valid in the next cycle; stall high 1 cycle.
- Back-to-back M-ops: the next start is accepted no earlier than the IDLE cycle after DONE. Minimum issue interval is XLEN+2 cycles.
- done never asserts on two consecutive cycles.

## Test plan
- MUL 7×6, XLEN=32:
  - stall high 33 cycles.
  - done one cycle with result=0x0000002A.
  - stall=0 during the done cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE.
- MUL same operands → 0x00000001.
- DIVU 100/7 → 0x0000000E.
- REMU 100/7 → 0x00000002.
- Each division completes in 33+1 cycles.
- DIVU x/0 → 0xFFFFFFFF.
- REMU 0x12345678/0 → 0x12345678.
- Both division-by-zero cases: done one cycle after accept, stall high exactly one cycle.
- MUL start, flush asserted on 10th RUN cycle:
  - next cycle state IDLE, stall=0.
  - done never pulses; result still holds the previous value.
- rst_n low mid-DIVU:
  - done=0, stall=0, result=0 immediately.
  - After release, MUL 3×5 → 15 with normal latency.
- funct3=001 with start=1: stall stays 0, no done, result unchanged.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// Unsigned RV32M multi-cycle unit (MUL, MULHU, DIVU, REMU): shift-add multiply / restoring divide, one bit per cycle.
// Latency: XLEN+1 cycles from accept to done (1 cycle for divide-by-zero); done and result are registered.
// Backpressure: stall (combinational) holds the pipeline during accept and RUN; flush aborts to IDLE with no done.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, funct3     M-op present in EX and its operation code (000 MUL, 011 MULHU, 101 DIVU, 111 REMU)
//   rs1_val, rs2_val  multiplicand/dividend, multiplier/divisor
//   flush             synchronous abort
//   stall             freeze upstream stages
//   done, result      one-cycle completion pulse, last completed value
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            CW    = $clog2(XLEN);
    localparam logic [CW-1:0] LAST  = CW'(XLEN - 1);
    localparam logic [2:0]    F3_MUL   = 3'b000;
    localparam logic [2:0]    F3_MULHU = 3'b011;
    localparam logic [2:0]    F3_DIVU  = 3'b101;
    localparam logic [2:0]    F3_REMU  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2:0]        op;       // op[2]: divide, op[1]: take upper half (MULHU / REMU)
    logic [2*XLEN-1:0] acc;      // multiply: {hi, multiplier/lo}; divide: {rem, quot}
    logic [XLEN-1:0]   opb;      // multiplicand or divisor

    logic              supported;
    logic              accept;
    logic              div_zero;
    logic              last_iter;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        supported = (funct3 == F3_MUL) || (funct3 == F3_MULHU) ||
                    (funct3 == F3_DIVU) || (funct3 == F3_REMU);
        accept    = start & supported & ~flush;
        div_zero  = funct3[2] & (rs2_val == '0);
        last_iter = (cnt == LAST);
    end

    // One iteration of either algorithm. The carry out of mul_sum becomes the
    // MSB after the right shift; the borrow of rem_diff decides the quotient bit
    // (rem_sh < 2*divisor, so a non-negative difference always fits XLEN bits).
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opb};
        rem_ge   = ~rem_diff[XLEN];
        if (op[2]) begin
            if (rem_ge) acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else        acc_nxt = {rem_sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0};
        end else begin
            if (acc[0]) acc_nxt = {mul_sum, acc[XLEN-1:1]};
            else        acc_nxt = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;   // start is still the finished instruction
            default: state_nxt = S_IDLE;
        endcase
        if (flush)  state_nxt = S_IDLE;
        if (!rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op     <= '0;
            acc    <= '0;
            opb    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && accept) begin
                op  <= funct3;
                cnt <= '0;
                opb <= funct3[2] ? rs2_val : rs1_val;
                acc <= {{XLEN{1'b0}}, (funct3[2] ? rs1_val : rs2_val)};
                if (div_zero) begin
                    result <= funct3[1] ? rs1_val : '1;
                    done   <= 1'b1;
                end
            end else if (state == S_RUN && !flush) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    result <= op[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
